// File: rtl/accumulator_arbiter.sv
// Round-robin owner of a shared accumulator.
// Each grant is one job: clear the accumulator, stream the owner's summands into it,
// then hold the final sum (tagged with owner ID, overflow and abort flags) until it is taken.
module accumulator_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 2,
  parameter int TIMEOUT    = 15
) (
  input  logic                        i_CLK,
  input  logic                        i_RESET,
  input  logic [N_REQ-1:0]            i_REQ,
  input  logic [N_REQ-1:0]            i_VALID,
  input  logic [N_REQ-1:0]            i_LAST,
  input  logic [N_REQ*DATA_WIDTH-1:0] i_SUMMAND,
  output logic [N_REQ-1:0]            o_GRANT,
  output logic [N_REQ-1:0]            o_READY,
  output logic                        o_ACC_CLK_ENABLE,
  output logic [DATA_WIDTH-1:0]       o_ACC_SUMMAND,
  output logic                        o_ACC_CLEAR,
  input  logic [DATA_WIDTH-1:0]       i_ACC_ACCUMULATION,
  output logic [DATA_WIDTH-1:0]       o_RESULT,
  output logic [ID_WIDTH-1:0]         o_RESULT_ID,
  output logic                        o_RESULT_OVF,
  output logic                        o_RESULT_ABORT,
  output logic                        o_RESULT_VALID,
  input  logic                        i_RESULT_READY
);

  localparam int CNT_WIDTH = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_SETTLE = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // Carry out of an unsigned add at DATA_WIDTH+1 bits: the accumulator wraps on this beat.
  function automatic logic carry_out(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_WIDTH];
  endfunction

  // Reduce an index in [0, 2*N_REQ) back into [0, N_REQ).
  function automatic logic [ID_WIDTH-1:0] wrap_index(input logic [ID_WIDTH:0] v);
    logic [ID_WIDTH:0] w;
    if (v >= (ID_WIDTH+1)'(N_REQ)) begin
      w = v - (ID_WIDTH+1)'(N_REQ);
    end else begin
      w = v;
    end
    return w[ID_WIDTH-1:0];
  endfunction

  state_t                  state_r;
  state_t                  state_next_s;
  logic [N_REQ-1:0]        grant_r;
  logic [ID_WIDTH-1:0]     owner_r;
  logic [ID_WIDTH-1:0]     ptr_r;
  logic [CNT_WIDTH-1:0]    idle_cnt_r;
  logic                    ovf_r;
  logic                    abort_r;
  logic [DATA_WIDTH-1:0]   result_r;
  logic [ID_WIDTH-1:0]     result_id_r;
  logic                    result_ovf_r;
  logic                    result_abort_r;
  logic                    result_valid_r;

  logic [N_REQ-1:0]        req_rot_s;
  logic                    pick_found_s;
  logic [ID_WIDTH-1:0]     pick_idx_s;
  logic [N_REQ-1:0]        pick_onehot_s;
  logic [ID_WIDTH-1:0]     ptr_next_s;
  logic [N_REQ-1:0]        ready_s;
  logic [DATA_WIDTH-1:0]   summand_mux_s;
  logic                    accept_s;
  logic                    last_beat_s;
  logic                    timeout_hit_s;

  // Round-robin pick: rotate requests so bit i is requester (ptr+i) mod N, take the lowest set bit.
  always_comb begin
    req_rot_s     = N_REQ'({i_REQ, i_REQ} >> ptr_r);
    pick_found_s  = 1'b0;
    pick_idx_s    = {ID_WIDTH{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_found_s && req_rot_s[i]) begin
        pick_found_s = 1'b1;
        pick_idx_s   = wrap_index({1'b0, ptr_r} + (ID_WIDTH+1)'(i));
      end else begin
        pick_found_s = pick_found_s;
      end
    end
    pick_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
    ptr_next_s    = wrap_index({1'b0, owner_r} + {{ID_WIDTH{1'b0}}, 1'b1});
  end

  // Beat path: ready only while streaming, summand muxed by the one-hot grant (zero when idle).
  always_comb begin
    summand_mux_s = {DATA_WIDTH{1'b0}};
    if (state_r == ST_STREAM) begin
      ready_s = grant_r;
    end else begin
      ready_s = {N_REQ{1'b0}};
    end
    for (int k = 0; k < N_REQ; k++) begin
      summand_mux_s = summand_mux_s |
                      (i_SUMMAND[k*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{grant_r[k]}});
    end
    accept_s      = |(ready_s & i_VALID);
    last_beat_s   = |(ready_s & i_VALID & i_LAST);
    timeout_hit_s = (idle_cnt_r == CNT_WIDTH'(TIMEOUT - 1));
  end

  // FSM state register.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state: one job per grant, arbitration only from IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_next_s = ST_CLEAR;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_next_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (accept_s) begin
          if (last_beat_s) begin
            state_next_s = ST_SETTLE;
          end else begin
            state_next_s = ST_STREAM;
          end
        end else if (timeout_hit_s) begin
          state_next_s = ST_SETTLE;
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      ST_SETTLE: begin
        state_next_s = ST_RESULT;
      end
      ST_RESULT: begin
        if (i_RESULT_READY) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESULT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs to the requesters and the accumulator; clear is forced while in reset.
  always_comb begin
    o_READY          = ready_s;
    o_ACC_CLK_ENABLE = accept_s;
    o_ACC_SUMMAND    = summand_mux_s;
    if (!i_RESET) begin
      o_ACC_CLEAR = 1'b1;
    end else if (state_r == ST_CLEAR) begin
      o_ACC_CLEAR = 1'b1;
    end else begin
      o_ACC_CLEAR = 1'b0;
    end
  end

  // Job bookkeeping: grant/owner, sticky overflow, idle timeout, result capture and handoff.
  always_ff @(posedge i_CLK) begin
    if (!i_RESET) begin
      grant_r        <= {N_REQ{1'b0}};
      owner_r        <= {ID_WIDTH{1'b0}};
      ptr_r          <= {ID_WIDTH{1'b0}};
      idle_cnt_r     <= {CNT_WIDTH{1'b0}};
      ovf_r          <= 1'b0;
      abort_r        <= 1'b0;
      result_r       <= {DATA_WIDTH{1'b0}};
      result_id_r    <= {ID_WIDTH{1'b0}};
      result_ovf_r   <= 1'b0;
      result_abort_r <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_found_s) begin
            grant_r <= pick_onehot_s;
            owner_r <= pick_idx_s;
          end
        end
        ST_CLEAR: begin
          ovf_r      <= 1'b0;
          abort_r    <= 1'b0;
          idle_cnt_r <= {CNT_WIDTH{1'b0}};
        end
        ST_STREAM: begin
          if (accept_s) begin
            ovf_r      <= ovf_r | carry_out(i_ACC_ACCUMULATION, summand_mux_s);
            idle_cnt_r <= {CNT_WIDTH{1'b0}};
          end else if (timeout_hit_s) begin
            abort_r <= 1'b1;
          end else begin
            idle_cnt_r <= idle_cnt_r + CNT_WIDTH'(1);
          end
        end
        ST_SETTLE: begin
          result_r       <= i_ACC_ACCUMULATION;
          result_id_r    <= owner_r;
          result_ovf_r   <= ovf_r;
          result_abort_r <= abort_r;
          result_valid_r <= 1'b1;
        end
        ST_RESULT: begin
          if (i_RESULT_READY) begin
            result_valid_r <= 1'b0;
            grant_r        <= {N_REQ{1'b0}};
            ptr_r          <= ptr_next_s;
          end
        end
        default: begin
          grant_r <= {N_REQ{1'b0}};
        end
      endcase
    end
  end

  assign o_GRANT        = grant_r;
  assign o_RESULT       = result_r;
  assign o_RESULT_ID    = result_id_r;
  assign o_RESULT_OVF   = result_ovf_r;
  assign o_RESULT_ABORT = result_abort_r;
  assign o_RESULT_VALID = result_valid_r;

endmodule

// File: tb/tb_accumulator_arbiter.sv
// Bench for accumulator_arbiter: drives requesters, models the attached accumulator,
// and predicts grants/results from the round-robin and summation rules.
module tb_accumulator_arbiter;

  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req, valid, last;
  logic [31:0]   summand;
  logic          res_ready;
  logic [7:0]    acc_q = 8'h00;
  logic [3:0]    o_GRANT, o_READY;
  logic          o_ACC_CLK_ENABLE, o_ACC_CLEAR;
  logic [7:0]    o_ACC_SUMMAND, o_RESULT;
  logic [1:0]    o_RESULT_ID;
  logic          o_RESULT_OVF, o_RESULT_ABORT, o_RESULT_VALID;

  int            n_pass, n_total;
  logic [7:0]    jb [0:7];

  accumulator_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(2), .TIMEOUT(TIMEOUT)) dut (
    .i_CLK(clk), .i_RESET(rst_n), .i_REQ(req), .i_VALID(valid), .i_LAST(last),
    .i_SUMMAND(summand), .o_GRANT(o_GRANT), .o_READY(o_READY),
    .o_ACC_CLK_ENABLE(o_ACC_CLK_ENABLE), .o_ACC_SUMMAND(o_ACC_SUMMAND),
    .o_ACC_CLEAR(o_ACC_CLEAR), .i_ACC_ACCUMULATION(acc_q), .o_RESULT(o_RESULT),
    .o_RESULT_ID(o_RESULT_ID), .o_RESULT_OVF(o_RESULT_OVF), .o_RESULT_ABORT(o_RESULT_ABORT),
    .o_RESULT_VALID(o_RESULT_VALID), .i_RESULT_READY(res_ready)
  );

  always #5 clk = ~clk;

  // Attached accumulator: clear has priority, otherwise add on enable, wrapping at 8 bits.
  always @(posedge clk) begin
    if (o_ACC_CLEAR) acc_q <= 8'h00;
    else if (o_ACC_CLK_ENABLE) acc_q <= acc_q + o_ACC_SUMMAND;
  end

  // Round-robin rule: first requesting index at or after the pointer, wrapping.
  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int off = 0; off < N; off++) begin
      if (r[(p + off) % N]) return (p + off) % N;
    end
    return 0;
  endfunction

  task automatic drive_req(input int k, input bit v, input bit l, input logic [7:0] s, input bit noise);
    logic [3:0] nv, nl;
    logic [31:0] ns;
    if (noise) begin
      nv = 4'($urandom); nl = 4'($urandom); ns = $urandom; req = 4'($urandom);
    end else begin
      nv = 4'h0; nl = 4'h0; ns = 32'h0;
    end
    nv[k] = v; nl[k] = l; ns[k*8 +: 8] = s;
    valid = nv; last = nl; summand = ns;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; valid = 4'h0; last = 4'h0; summand = 32'h0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a grant; returns at the negedge where it is first visible.
  task automatic wait_grant(output logic [3:0] g, output logic clr);
    g = 4'h0; clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (o_GRANT !== 4'h0) begin
        g = o_GRANT; clr = o_ACC_CLEAR;
        break;
      end
    end
  endtask

  // Run one job for requester k from the grant negedge to the handshake; returns observations.
  task automatic do_job(input int k, input int nb, input int gap, input bit to, input int hold,
                        input bit noise, output int en_cnt, output logic v_settle,
                        output logic v_res, output logic rdy_pre_to, output bit stable,
                        output bit idle_after, output logic [7:0] r, output logic [1:0] rid,
                        output logic rovf, output logic rab);
    en_cnt = 0; rdy_pre_to = 1'b0;
    @(negedge clk);
    for (int b = 0; b < nb; b++) begin
      for (int g = 0; g < gap; g++) begin
        drive_req(k, 1'b0, 1'b0, 8'h00, noise); #1;
        if (o_ACC_CLK_ENABLE) en_cnt++;
        @(negedge clk);
      end
      drive_req(k, 1'b1, (!to && b == nb - 1), jb[b], noise); #1;
      if (o_ACC_CLK_ENABLE) en_cnt++;
      @(negedge clk);
    end
    if (to) begin
      for (int t = 0; t < TIMEOUT; t++) begin
        drive_req(k, 1'b0, 1'b0, 8'h00, noise); #1;
        if (t == TIMEOUT - 1) rdy_pre_to = o_READY[k];
        if (o_ACC_CLK_ENABLE) en_cnt++;
        @(negedge clk);
      end
    end
    drive_req(k, 1'b0, 1'b0, 8'h00, 1'b0);
    v_settle = o_RESULT_VALID;
    @(negedge clk);
    v_res = o_RESULT_VALID; r = o_RESULT; rid = o_RESULT_ID; rovf = o_RESULT_OVF; rab = o_RESULT_ABORT;
    stable = 1'b1;
    repeat (hold) begin
      @(negedge clk);
      if (o_RESULT !== r || o_RESULT_ID !== rid || o_RESULT_OVF !== rovf ||
          o_RESULT_ABORT !== rab || o_RESULT_VALID !== 1'b1 || o_GRANT !== (4'b0001 << k))
        stable = 1'b0;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    idle_after = (o_GRANT === 4'h0 && o_RESULT_VALID === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; valid = 4'hF; last = 4'h0; summand = 32'hFFFF_FFFF; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (o_GRANT !== 4'h0) $display("FAIL reset_grant: got %b want 0000", o_GRANT); else n_pass++;
    n_total++; if (o_READY !== 4'h0) $display("FAIL reset_ready: got %b want 0000", o_READY); else n_pass++;
    n_total++; if (o_RESULT_VALID !== 1'b0 || o_RESULT !== 8'h00 || o_RESULT_ID !== 2'd0 ||
                   o_RESULT_OVF !== 1'b0 || o_RESULT_ABORT !== 1'b0)
      $display("FAIL reset_result: got v=%b r=%h id=%0d ovf=%b ab=%b want all 0",
               o_RESULT_VALID, o_RESULT, o_RESULT_ID, o_RESULT_OVF, o_RESULT_ABORT); else n_pass++;
    n_total++; if (o_ACC_CLEAR !== 1'b1) $display("FAIL reset_clear: got %b want 1", o_ACC_CLEAR); else n_pass++;
    n_total++; if (o_ACC_SUMMAND !== 8'h00 || o_ACC_CLK_ENABLE !== 1'b0)
      $display("FAIL reset_acc_if: got sum=%h en=%b want 00/0", o_ACC_SUMMAND, o_ACC_CLK_ENABLE); else n_pass++;
    req = 4'h0; valid = 4'h0; summand = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (o_ACC_CLEAR !== 1'b0 || o_GRANT !== 4'h0)
      $display("FAIL idle_after_reset: got clr=%b grant=%b want 0/0000", o_ACC_CLEAR, o_GRANT); else n_pass++;
  endtask

  task automatic test_single_job();
    logic [3:0] g; logic clr, vs, vr, rp, ro, ra; bit st, ia; int en; logic [7:0] r; logic [1:0] id;
    req = 4'b0010;
    wait_grant(g, clr);
    req = 4'b0000;
    n_total++; if (g !== 4'b0010) $display("FAIL single_grant: got %b want 0010", g); else n_pass++;
    n_total++; if (clr !== 1'b1) $display("FAIL single_clear: got %b want 1", clr); else n_pass++;
    jb[0] = 8'h10; jb[1] = 8'h20; jb[2] = 8'h30;
    do_job(1, 3, 0, 1'b0, 0, 1'b0, en, vs, vr, rp, st, ia, r, id, ro, ra);
    n_total++; if (en !== 3) $display("FAIL single_enables: got %0d want 3", en); else n_pass++;
    n_total++; if (r !== 8'h60 || id !== 2'd1 || ro !== 1'b0 || ra !== 1'b0)
      $display("FAIL single_result: got r=%h id=%0d ovf=%b ab=%b want 60/1/0/0", r, id, ro, ra); else n_pass++;
    n_total++; if (vs !== 1'b0 || vr !== 1'b1)
      $display("FAIL single_latency: got settle=%b result=%b want 0/1", vs, vr); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0] g; logic clr, vs, vr, rp, ro, ra; bit st, ia; int en; logic [7:0] r; logic [1:0] id;
    apply_reset();
    for (int j = 0; j < 5; j++) begin
      req = 4'b1111;
      wait_grant(g, clr);
      n_total++; if (g !== (4'b0001 << (j % N))) $display("FAIL rr_grant%0d: got %b want %b", j, g, 4'b0001 << (j % N)); else n_pass++;
      jb[0] = 8'h01;
      do_job(j % N, 1, 0, 1'b0, 0, 1'b0, en, vs, vr, rp, st, ia, r, id, ro, ra);
      n_total++; if (r !== 8'h01 || id !== 2'(j % N))
        $display("FAIL rr_result%0d: got r=%h id=%0d want 01/%0d", j, r, id, j % N); else n_pass++;
      n_total++; if (ia !== 1'b1) $display("FAIL rr_gap%0d: got %b want 1", j, ia); else n_pass++;
    end
  endtask

  task automatic test_overflow();
    logic [3:0] g; logic clr, vs, vr, rp, ro, ra; bit st, ia; int en; logic [7:0] r; logic [1:0] id;
    req = 4'b0100;
    wait_grant(g, clr);
    n_total++; if (g !== 4'b0100) $display("FAIL ovf_grant: got %b want 0100", g); else n_pass++;
    jb[0] = 8'hF0; jb[1] = 8'h20;
    do_job(2, 2, 1, 1'b0, 0, 1'b0, en, vs, vr, rp, st, ia, r, id, ro, ra);
    n_total++; if (r !== 8'h10 || ro !== 1'b1 || id !== 2'd2 || ra !== 1'b0)
      $display("FAIL ovf_result: got r=%h ovf=%b id=%0d ab=%b want 10/1/2/0", r, ro, id, ra); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [3:0] g; logic clr, vs, vr, rp, ro, ra; bit st, ia; int en; logic [7:0] r; logic [1:0] id;
    req = 4'b0011;
    wait_grant(g, clr);
    n_total++; if (g !== 4'b0001) $display("FAIL to_grant0: got %b want 0001", g); else n_pass++;
    jb[0] = 8'h05;
    do_job(0, 1, 0, 1'b1, 0, 1'b0, en, vs, vr, rp, st, ia, r, id, ro, ra);
    n_total++; if (rp !== 1'b1) $display("FAIL to_still_streaming: got %b want 1", rp); else n_pass++;
    n_total++; if (ra !== 1'b1 || r !== 8'h05 || ro !== 1'b0 || id !== 2'd0)
      $display("FAIL to_result: got ab=%b r=%h ovf=%b id=%0d want 1/05/0/0", ra, r, ro, id); else n_pass++;
    wait_grant(g, clr);
    n_total++; if (g !== 4'b0010) $display("FAIL to_grant1: got %b want 0010", g); else n_pass++;
    do_job(1, 0, 0, 1'b1, 0, 1'b0, en, vs, vr, rp, st, ia, r, id, ro, ra);
    n_total++; if (ra !== 1'b1 || r !== 8'h00 || id !== 2'd1 || en !== 0)
      $display("FAIL to_zero_beat: got ab=%b r=%h id=%0d en=%0d want 1/00/1/0", ra, r, id, en); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [3:0] g; logic clr, vs, vr, rp, ro, ra; bit st, ia; int en; logic [7:0] r; logic [1:0] id;
    req = 4'b1111;
    wait_grant(g, clr);
    n_total++; if (g !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", g); else n_pass++;
    jb[0] = 8'h2A; jb[1] = 8'h30;
    do_job(2, 2, 1, 1'b0, 5, 1'b0, en, vs, vr, rp, st, ia, r, id, ro, ra);
    n_total++; if (st !== 1'b1) $display("FAIL bp_stable: got %b want 1", st); else n_pass++;
    n_total++; if (r !== 8'h5A || id !== 2'd2) $display("FAIL bp_result: got r=%h id=%0d want 5a/2", r, id); else n_pass++;
    n_total++; if (ia !== 1'b1) $display("FAIL bp_idle: got %b want 1", ia); else n_pass++;
    wait_grant(g, clr);
    n_total++; if (g !== 4'b1000) $display("FAIL bp_next_grant: got %b want 1000", g); else n_pass++;
    jb[0] = 8'h5A;
    do_job(3, 1, 0, 1'b0, 0, 1'b0, en, vs, vr, rp, st, ia, r, id, ro, ra);
    n_total++; if (r !== 8'h5A || id !== 2'd3) $display("FAIL bp_result3: got r=%h id=%0d want 5a/3", r, id); else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    logic [3:0] g; logic clr, vs, vr, rp, ro, ra; bit st, ia; int en; logic [7:0] r; logic [1:0] id;
    req = 4'b1000;
    wait_grant(g, clr);
    n_total++; if (g !== 4'b1000) $display("FAIL mid_grant: got %b want 1000", g); else n_pass++;
    req = 4'b0000;
    @(negedge clk);
    drive_req(3, 1'b1, 1'b0, 8'h44, 1'b0);
    @(negedge clk);
    drive_req(3, 1'b1, 1'b0, 8'h11, 1'b0);
    rst_n = 1'b0; #1;
    n_total++; if (o_ACC_CLEAR !== 1'b1) $display("FAIL mid_clear_comb: got %b want 1", o_ACC_CLEAR); else n_pass++;
    @(negedge clk);
    n_total++; if (o_GRANT !== 4'h0 || o_READY !== 4'h0 || o_ACC_CLK_ENABLE !== 1'b0)
      $display("FAIL mid_drop: got g=%b rdy=%b en=%b want 0", o_GRANT, o_READY, o_ACC_CLK_ENABLE); else n_pass++;
    n_total++; if (o_RESULT_VALID !== 1'b0 || o_RESULT !== 8'h00 || o_RESULT_ID !== 2'd0)
      $display("FAIL mid_result_clr: got v=%b r=%h id=%0d want 0/00/0", o_RESULT_VALID, o_RESULT, o_RESULT_ID); else n_pass++;
    req = 4'b1001; valid = 4'h0; last = 4'h0; summand = 32'h0;
    rst_n = 1'b1;
    wait_grant(g, clr);
    n_total++; if (g !== 4'b0001) $display("FAIL mid_ptr0: got %b want 0001", g); else n_pass++;
    n_total++; if (o_RESULT_VALID !== 1'b0) $display("FAIL mid_no_result: got %b want 0", o_RESULT_VALID); else n_pass++;
    jb[0] = 8'h07;
    do_job(0, 1, 0, 1'b0, 0, 1'b0, en, vs, vr, rp, st, ia, r, id, ro, ra);
    n_total++; if (r !== 8'h07 || id !== 2'd0) $display("FAIL mid_after: got r=%h id=%0d want 07/0", r, id); else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] g, r4; logic clr, vs, vr, rp, ro, ra; bit st, ia, to; int en, k, nb, sum, ptr_m;
    logic [7:0] r; logic [1:0] id;
    apply_reset();
    ptr_m = 0;
    for (int j = 0; j < 30; j++) begin
      r4 = 4'($urandom_range(1, 15));
      req = r4;
      k = rr_pick(r4, ptr_m);
      wait_grant(g, clr);
      n_total++; if (g !== (4'b0001 << k)) $display("FAIL rnd_grant%0d: got %b want %b", j, g, 4'b0001 << k); else n_pass++;
      to = ($urandom_range(0, 5) == 0);
      nb = to ? $urandom_range(0, 2) : $urandom_range(1, 4);
      sum = 0;
      for (int b = 0; b < nb; b++) begin
        jb[b] = 8'($urandom);
        sum += int'(jb[b]);
      end
      do_job(k, nb, $urandom_range(0, 2), to, $urandom_range(0, 3), 1'b1,
             en, vs, vr, rp, st, ia, r, id, ro, ra);
      n_total++; if (r !== 8'(sum % 256) || id !== 2'(k))
        $display("FAIL rnd_result%0d: got r=%h id=%0d want %h/%0d", j, r, id, sum % 256, k); else n_pass++;
      n_total++; if (ro !== (sum > 255) || ra !== to)
        $display("FAIL rnd_flags%0d: got ovf=%b ab=%b want %b/%b", j, ro, ra, sum > 255, to); else n_pass++;
      n_total++; if (en !== nb) $display("FAIL rnd_enables%0d: got %0d want %0d", j, en, nb); else n_pass++;
      n_total++; if (st !== 1'b1 || ia !== 1'b1)
        $display("FAIL rnd_hold%0d: got stable=%b idle=%b want 1/1", j, st, ia); else n_pass++;
      ptr_m = (k + 1) % N;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_single_job();
    test_round_robin();
    test_overflow();
    test_timeout();
    test_backpressure();
    test_reset_mid_job();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
